// File: rtl/zigzag_rle.sv
// Zigzag scan and zero-run-length coder for one 8x8 block of quantised coefficients.
// Emits a DC symbol, then (run, value) pairs for non-zero ACs, then an end-of-block marker.
module zigzag_rle #(
    parameter int unsigned W     = 32,
    parameter int unsigned RUN_W = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              blk_valid_i,
    input  logic [64*W-1:0]   blk_in_i,
    output logic              blk_ready_o,
    output logic              sym_valid_o,
    input  logic              sym_ready_i,
    output logic [RUN_W-1:0]  sym_run_o,
    output logic [W-1:0]      sym_val_o,
    output logic              sym_dc_o,
    output logic              sym_eob_o,
    output logic              done_o
);

    typedef enum logic [1:0] {StIdle, StScan, StEmit, StEob} state_e;

    localparam logic [5:0] ZigzagLut [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_e           state_q, state_d;
    logic [5:0]       p_q, p_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [W-1:0]     blk_q [64];
    logic [W-1:0]     coef;
    logic             capture;

    logic             blk_ready_q, blk_ready_d;
    logic             sym_valid_q, sym_valid_d;
    logic [RUN_W-1:0] sym_run_q, sym_run_d;
    logic [W-1:0]     sym_val_q, sym_val_d;
    logic             sym_dc_q, sym_dc_d;
    logic             sym_eob_q, sym_eob_d;
    logic             done_q, done_d;

    assign coef    = blk_q[ZigzagLut[p_q]];
    assign capture = en_i && blk_valid_i && (state_q == StIdle);

    // Block storage carries no reset: it is only read after a capture.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            for (int i = 0; i < 64; i++) begin
                blk_q[i] <= blk_in_i[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            p_q     <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        run_d   = run_q;
        if (en_i) begin
            unique case (state_q)
                StIdle: begin
                    if (blk_valid_i) begin
                        state_d = StScan;
                        p_d     = '0;
                        run_d   = '0;
                    end
                end
                StScan: begin
                    if (p_q == 6'd0) begin
                        state_d = StEmit;
                    end else if (coef == '0) begin
                        run_d = run_q + RUN_W'(1);
                        if (p_q == 6'd63) state_d = StEob;
                        else              p_d     = p_q + 6'd1;
                    end else begin
                        run_d   = '0;
                        state_d = StEmit;
                    end
                end
                StEmit: begin
                    if (sym_ready_i) begin
                        if (p_q == 6'd63) begin
                            state_d = StEob;
                        end else begin
                            p_d     = p_q + 6'd1;
                            state_d = StScan;
                        end
                    end
                end
                StEob: begin
                    if (sym_ready_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output registers are loaded from the transition being taken this cycle.
    always_comb begin
        sym_run_d   = sym_run_q;
        sym_val_d   = sym_val_q;
        sym_dc_d    = sym_dc_q;
        done_d      = done_q;
        sym_valid_d = (state_d == StEmit) || (state_d == StEob);
        sym_eob_d   = (state_d == StEob);
        blk_ready_d = (state_d == StIdle);
        if (en_i) begin
            done_d = (state_q == StEob) && (state_d == StIdle);
            if ((state_q == StScan) && (state_d == StEmit)) begin
                sym_run_d = (p_q == 6'd0) ? '0 : run_q;
                sym_val_d = coef;
                sym_dc_d  = (p_q == 6'd0);
            end
            if ((state_q != StEob) && (state_d == StEob)) begin
                sym_run_d = '0;
                sym_val_d = '0;
                sym_dc_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blk_ready_q <= 1'b1;
            sym_valid_q <= 1'b0;
            sym_run_q   <= '0;
            sym_val_q   <= '0;
            sym_dc_q    <= 1'b0;
            sym_eob_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            blk_ready_q <= blk_ready_d;
            sym_valid_q <= sym_valid_d;
            sym_run_q   <= sym_run_d;
            sym_val_q   <= sym_val_d;
            sym_dc_q    <= sym_dc_d;
            sym_eob_q   <= sym_eob_d;
            done_q      <= done_d;
        end
    end

    assign blk_ready_o = blk_ready_q;
    assign sym_valid_o = sym_valid_q;
    assign sym_run_o   = sym_run_q;
    assign sym_val_o   = sym_val_q;
    assign sym_dc_o    = sym_dc_q;
    assign sym_eob_o   = sym_eob_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_zigzag_rle.sv
// Directed bench for zigzag_rle: reset, DC-only, mixed, last-position, backpressure,
// clock-enable freeze and mid-block reset scenarios.
module tb_zigzag_rle;
    localparam int unsigned W     = 32;
    localparam int unsigned RUN_W = 6;

    typedef logic [3+RUN_W+W-1:0] tuple_t;  // {valid, eob, dc, run, val}

    logic             clk = 1'b0;
    logic             reset, en, blk_valid, sym_ready;
    logic [64*W-1:0]  blk_in;
    logic             blk_ready, sym_valid, sym_dc, sym_eob, done;
    logic [RUN_W-1:0] sym_run;
    logic [W-1:0]     sym_val;
    tuple_t           obs;

    int n_checks = 0;
    int n_pass   = 0;

    zigzag_rle #(.W(W), .RUN_W(RUN_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (en),
        .blk_valid_i (blk_valid),
        .blk_in_i    (blk_in),
        .blk_ready_o (blk_ready),
        .sym_valid_o (sym_valid),
        .sym_ready_i (sym_ready),
        .sym_run_o   (sym_run),
        .sym_val_o   (sym_val),
        .sym_dc_o    (sym_dc),
        .sym_eob_o   (sym_eob),
        .done_o      (done)
    );

    always #5 clk = ~clk;
    assign obs = {sym_valid, sym_eob, sym_dc, sym_run, sym_val};

    function automatic tuple_t sym(input logic eob, input logic dc, input int run, input int val);
        return {1'b1, eob, dc, RUN_W'(run), W'(val)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture();
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (sym_valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; en = 1'b0; blk_valid = 1'b0; sym_ready = 1'b0; blk_in = '0;
        step();
        step();
        n_checks++;
        if ({sym_valid, sym_eob, sym_dc, done, blk_ready} !== 5'b00001)
            $display("FAIL reset_flags: got %b want 00001", {sym_valid, sym_eob, sym_dc, done, blk_ready});
        else n_pass++;
        n_checks++;
        if ({sym_run, sym_val} !== '0)
            $display("FAIL reset_data: got run=%0d val=%0d want 0/0", sym_run, sym_val);
        else n_pass++;
        reset = 1'b0; en = 1'b1;
        step();
        wait_valid(3, n);
        n_checks++;
        if (sym_valid !== 1'b0 || blk_ready !== 1'b1)
            $display("FAIL idle_quiet: got valid=%b ready=%b want 0/1", sym_valid, blk_ready);
        else n_pass++;
    endtask

    task automatic test_dc_only();
        int n;
        blk_in = '0;
        blk_in[0*W +: W] = 5;
        sym_ready = 1'b1;
        capture();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 1, 0, 5) || n !== 1)
            $display("FAIL dc_only_dc: got %h after %0d want %h after 1", obs, n, sym(0, 1, 0, 5));
        else n_pass++;
        step();
        wait_valid(100, n);
        n_checks++;
        if (obs !== sym(1, 0, 0, 0) || n !== 63)
            $display("FAIL dc_only_eob: got %h after %0d want %h after 63", obs, n, sym(1, 0, 0, 0));
        else n_pass++;
        step();
        n_checks++;
        if ({done, sym_valid, blk_ready} !== 3'b101)
            $display("FAIL dc_only_done: got %b want 101", {done, sym_valid, blk_ready});
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b0)
            $display("FAIL dc_only_done_pulse: got %b want 0", done);
        else n_pass++;
    endtask

    task automatic test_mixed();
        int n;
        blk_in = '0;
        blk_in[0*W +: W] = -3;
        blk_in[1*W +: W] = 7;
        blk_in[16*W +: W] = 4;
        sym_ready = 1'b1;
        capture();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 1, 0, -3))
            $display("FAIL mixed_dc: got %h want %h", obs, sym(0, 1, 0, -3));
        else n_pass++;
        step();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 0, 0, 7))
            $display("FAIL mixed_ac1: got %h want %h", obs, sym(0, 0, 0, 7));
        else n_pass++;
        step();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 0, 1, 4))
            $display("FAIL mixed_ac2: got %h want %h", obs, sym(0, 0, 1, 4));
        else n_pass++;
        step();
        wait_valid(100, n);
        n_checks++;
        if (obs !== sym(1, 0, 0, 0))
            $display("FAIL mixed_eob: got %h want %h", obs, sym(1, 0, 0, 0));
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL mixed_done: got %b want 1", done);
        else n_pass++;
    endtask

    task automatic test_last_pos();
        int n;
        blk_in = '0;
        blk_in[63*W +: W] = 9;
        sym_ready = 1'b1;
        capture();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 1, 0, 0))
            $display("FAIL last_dc_zero: got %h want %h", obs, sym(0, 1, 0, 0));
        else n_pass++;
        step();
        wait_valid(100, n);
        n_checks++;
        if (obs !== sym(0, 0, 62, 9))
            $display("FAIL last_run62: got %h want %h", obs, sym(0, 0, 62, 9));
        else n_pass++;
        step();
        n_checks++;
        if (obs !== sym(1, 0, 0, 0))
            $display("FAIL last_eob: got %h want %h", obs, sym(1, 0, 0, 0));
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL last_done: got %b want 1", done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        blk_in = '0;
        blk_in[0*W +: W] = -3;
        blk_in[1*W +: W] = 7;
        blk_in[16*W +: W] = 4;
        sym_ready = 1'b1;
        capture();
        wait_valid(10, n);
        step();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 0, 0, 7))
            $display("FAIL bp_first: got %h want %h", obs, sym(0, 0, 0, 7));
        else n_pass++;
        sym_ready = 1'b0;
        blk_in = '0;
        blk_in[0*W +: W] = 11;
        blk_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            step();
            if (obs !== sym(0, 0, 0, 7) || blk_ready !== 1'b0) bad++;
        end
        blk_valid = 1'b0;
        n_checks++;
        if (bad !== 0)
            $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
        else n_pass++;
        en = 1'b0;
        sym_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (obs !== sym(0, 0, 0, 7))
            $display("FAIL en_freeze: got %h want %h", obs, sym(0, 0, 0, 7));
        else n_pass++;
        en = 1'b1;
        step();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 0, 1, 4))
            $display("FAIL bp_next: got %h want %h", obs, sym(0, 0, 1, 4));
        else n_pass++;
        step();
        wait_valid(100, n);
        n_checks++;
        if (obs !== sym(1, 0, 0, 0))
            $display("FAIL bp_eob: got %h want %h", obs, sym(1, 0, 0, 0));
        else n_pass++;
        step();
        bad = 0;
        repeat (4) begin
            step();
            if (sym_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL bp_no_capture: got %0d valid cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        blk_in = '0;
        blk_in[0*W +: W] = -3;
        blk_in[1*W +: W] = 7;
        sym_ready = 1'b0;
        capture();
        wait_valid(10, n);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({sym_valid, blk_ready, done} !== 3'b010)
            $display("FAIL rst_mid: got %b want 010", {sym_valid, blk_ready, done});
        else n_pass++;
        sym_ready = 1'b1;
        bad = 0;
        repeat (70) begin
            step();
            if (done !== 1'b0 || sym_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL rst_discard: got %0d active cycles want 0", bad);
        else n_pass++;
        blk_in = '0;
        blk_in[0*W +: W] = 2;
        blk_in[2*W +: W] = -1;
        capture();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 1, 0, 2))
            $display("FAIL rst_after_dc: got %h want %h", obs, sym(0, 1, 0, 2));
        else n_pass++;
        step();
        wait_valid(10, n);
        n_checks++;
        if (obs !== sym(0, 0, 4, -1))
            $display("FAIL rst_after_ac: got %h want %h", obs, sym(0, 0, 4, -1));
        else n_pass++;
        step();
        wait_valid(100, n);
        n_checks++;
        if (obs !== sym(1, 0, 0, 0))
            $display("FAIL rst_after_eob: got %h want %h", obs, sym(1, 0, 0, 0));
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL rst_after_done: got %b want 1", done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dc_only();
        test_mixed();
        test_last_pos();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
